// File: rtl/button_event_pkg.sv
// Shared types and constants for the button event input path.
// Optional timestamp feature: BUTTON_EVENT_TIMESTAMP_EN.
package button_event_pkg;

    localparam int MAX_BUTTONS = 16;
    localparam int MAX_IDX_W   = 4;

    localparam logic EV_RELEASE = 1'b0;
    localparam logic EV_PRESS   = 1'b1;

    // A single button still needs one index bit to form a legal vector.
    function automatic int ev_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic                 ev_type;
        logic [MAX_IDX_W-1:0] index;
    } ev_code_t;

endpackage

// File: rtl/button_event_if.sv
// Event stream (valid/ready) plus sticky overflow status between the button block and the SoC.
// Optional timestamp feature: BUTTON_EVENT_TIMESTAMP_EN.
interface button_event_if
    import button_event_pkg::*;
#(
    parameter int NUM_BUTTONS = 4
`ifdef BUTTON_EVENT_TIMESTAMP_EN
    , parameter int TS_WIDTH = 16
`endif
);
    localparam int CODE_W = 1 + ev_idx_w(NUM_BUTTONS);

    // event_code/event_time are held while event_valid && !event_ready; a beat moves on valid && ready.
    logic              event_valid;
    logic              event_ready;
    logic [CODE_W-1:0] event_code;
    logic              overflow;
    logic              overflow_clear;
`ifdef BUTTON_EVENT_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] event_time;
`endif

    modport master (
`ifdef BUTTON_EVENT_TIMESTAMP_EN
        output event_time,
`endif
        output event_valid, event_code, overflow,
        input  event_ready, overflow_clear
    );

    modport slave (
`ifdef BUTTON_EVENT_TIMESTAMP_EN
        input  event_time,
`endif
        input  event_valid, event_code, overflow,
        output event_ready, overflow_clear
    );

endinterface

// File: rtl/button_debouncer.sv
// One button: 2-flop synchronizer, stability counter and debounced level with a flip strobe.
// flip_o is high during the cycle whose closing edge toggles state_o.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic state_o,
    output logic flip_o
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             state_q;
    logic [CNT_W-1:0] cnt_q;

    assign flip_o  = (sync2_q != state_q) && (cnt_q == CNT_LAST);
    assign state_o = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            if (sync2_q == state_q) begin
                cnt_q <= '0;
            end else if (flip_o) begin
                state_q <= ~state_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/button_event_input.sv
// Debounced button levels plus a press/release event queue with sticky overflow.
// Define BUTTON_EVENT_TIMESTAMP_EN to add a free-running timestamp carried with each event.
module button_event_input
    import button_event_pkg::*;
#(
    parameter int NUM_BUTTONS     = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int FIFO_DEPTH      = 4,
    parameter int TS_WIDTH        = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_BUTTONS-1:0] buttons_i,
    output logic [NUM_BUTTONS-1:0] state_o,
    button_event_if.master         bus
);
    localparam int IDX_W  = ev_idx_w(NUM_BUTTONS);
    localparam int CODE_W = 1 + IDX_W;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
`ifdef BUTTON_EVENT_TIMESTAMP_EN
    localparam int ENTRY_W = TS_WIDTH + CODE_W;
`else
    localparam int ENTRY_W = CODE_W;
`endif

    if (NUM_BUTTONS < 1 || NUM_BUTTONS > MAX_BUTTONS || DEBOUNCE_CYCLES < 2 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TS_WIDTH < 1) begin : g_bad_params
        $error("button_event_input: illegal parameter set");
    end

    logic [NUM_BUTTONS-1:0] state;
    logic [NUM_BUTTONS-1:0] flip;
    logic [NUM_BUTTONS-1:0] pending_q, pending_d;
    logic [NUM_BUTTONS-1:0] ptype_q, ptype_d;
    logic [NUM_BUTTONS-1:0] sel_oh;
    logic                   sel_valid;
    ev_code_t               sel_code;
    logic                   drop;
    logic                   overflow_q, overflow_d;
    logic [PTR_W:0]         wr_q, rd_q;
    logic [ENTRY_W-1:0]     mem_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0]     push_entry;
    logic                   full, empty, push, pop;

    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_btn
        button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk     (clk),
            .rst_n   (rst_n),
            .btn_i   (buttons_i[g]),
            .state_o (state[g]),
            .flip_o  (flip[g])
        );
    end

    assign state_o = state;

`ifdef BUTTON_EVENT_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_q;
    logic [TS_WIDTH-1:0] pts_q [NUM_BUTTONS];
    logic [TS_WIDTH-1:0] pts_d [NUM_BUTTONS];
    logic [TS_WIDTH-1:0] sel_ts;
`endif

    // Lowest-index pending button wins the single push slot.
    always_comb begin
        sel_valid = 1'b0;
        sel_oh    = '0;
        sel_code  = '0;
`ifdef BUTTON_EVENT_TIMESTAMP_EN
        sel_ts    = '0;
`endif
        for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel_valid        = 1'b1;
                sel_oh           = NUM_BUTTONS'(1) << i;
                sel_code.ev_type = ptype_q[i];
                sel_code.index   = MAX_IDX_W'(i);
`ifdef BUTTON_EVENT_TIMESTAMP_EN
                sel_ts           = pts_q[i];
`endif
            end
        end
    end

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[PTR_W] != rd_q[PTR_W]) && (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
    assign push  = sel_valid && !full;
    assign pop   = !empty && bus.event_ready;

`ifdef BUTTON_EVENT_TIMESTAMP_EN
    assign push_entry = {sel_ts, sel_code.ev_type, sel_code.index[IDX_W-1:0]};
`else
    assign push_entry = {sel_code.ev_type, sel_code.index[IDX_W-1:0]};
`endif

    // A flip on a button whose previous event is still pending is lost, never merged.
    always_comb begin
        pending_d = pending_q;
        ptype_d   = ptype_q;
        drop      = 1'b0;
`ifdef BUTTON_EVENT_TIMESTAMP_EN
        pts_d     = pts_q;
`endif
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (push && sel_oh[i]) pending_d[i] = 1'b0;
            if (flip[i]) begin
                if (pending_q[i]) begin
                    drop = 1'b1;
                end else begin
                    pending_d[i] = 1'b1;
                    ptype_d[i]   = state[i] ? EV_RELEASE : EV_PRESS;
`ifdef BUTTON_EVENT_TIMESTAMP_EN
                    pts_d[i]     = ts_q;
`endif
                end
            end
        end
        overflow_d = drop | (overflow_q & ~bus.overflow_clear);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= '0;
            ptype_q    <= '0;
            overflow_q <= 1'b0;
            wr_q       <= '0;
            rd_q       <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++) mem_q[k] <= '0;
        end else begin
            pending_q  <= pending_d;
            ptype_q    <= ptype_d;
            overflow_q <= overflow_d;
            if (push) begin
                mem_q[wr_q[PTR_W-1:0]] <= push_entry;
                wr_q <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
        end
    end

`ifdef BUTTON_EVENT_TIMESTAMP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q <= '0;
            for (int k = 0; k < NUM_BUTTONS; k++) pts_q[k] <= '0;
        end else begin
            ts_q  <= ts_q + 1'b1;
            pts_q <= pts_d;
        end
    end

    assign bus.event_time = mem_q[rd_q[PTR_W-1:0]][ENTRY_W-1:CODE_W];
`endif

    assign bus.event_valid = !empty;
    assign bus.event_code  = mem_q[rd_q[PTR_W-1:0]][CODE_W-1:0];
    assign bus.overflow    = overflow_q;

endmodule
